fc_result_collector: RTL and testbench

//  Packs the 10 per-class scores from the final FC layer into the 80-bit word consumed by the result comparator / LED stage.

---
 rtl/fc_result_collector_pkg.sv | 20 ++
 rtl/fc_result_collector_argmax_tracker.sv | 37 +++
 rtl/fc_result_collector.sv | 151 +++++++++++++++
 tb/tb_fc_result_collector.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_result_collector_pkg.sv
// Shared sizes and FSM encodings for the FC result collector.
// Optional argmax build: define FC_COLLECT_ARGMAX_EN.
package fc_result_collector_pkg;

  localparam int N_CLASS   = 10;
  localparam int DW        = 8;
  localparam int CLS_IDX_W = 4;
  localparam int TIMEOUT   = 1024;

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int SH_W  = (N_CLASS - 1) * DW;
  localparam int OUT_W = N_CLASS * DW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/fc_result_collector_argmax_tracker.sv
// Running signed maximum over the beats of one frame.
// best_* already include the beat currently on data/idx.
module argmax_tracker
  import fc_result_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DW-1:0]        data,
  input  logic [CLS_IDX_W-1:0] idx,
  output logic [CLS_IDX_W-1:0] best_idx,
  output logic [DW-1:0]        best_score
);

  logic [DW-1:0]        score_q;
  logic [CLS_IDX_W-1:0] idx_q;
  logic                 take;

  // strict compare keeps the earlier index on ties
  assign take = clear ||
    ($signed(data) > $signed(score_q));
  assign best_score = take ? data : score_q;
  assign best_idx   = take ? idx  : idx_q;

  // hold the running best between beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_q <= '0;
      idx_q   <= '0;
    end else if (en) begin
      score_q <= best_score;
      idx_q   <= best_idx;
    end
  end

endmodule

// File: rtl/fc_result_collector.sv
// Packs 10 FC score beats into one 80-bit word, drops bad frames.
// Optional argmax build: define FC_COLLECT_ARGMAX_EN.
module fc_result_collector
  import fc_result_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  output logic [OUT_W-1:0]     dout,
  output logic                 dout_valid,
  output logic                 err,
  output logic                 busy,
  output logic [CLS_IDX_W-1:0] class_idx,
  output logic [DW-1:0]        class_score
);

  state_t               state;
  state_t               state_nxt;
  logic [CLS_IDX_W-1:0] cnt;
  logic [TMR_W-1:0]     tmr;
  logic [SH_W-1:0]      shadow;
  logic                 last_beat;
  logic                 tmo;
  logic                 first;
  logic                 good;
  logic                 bad;

  assign last_beat = cnt == CLS_IDX_W'(N_CLASS - 1);
  assign tmo = !in_valid &&
    (tmr == TMR_W'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (in_valid && !in_last)
          state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (in_valid) begin
          if (in_last)
            state_nxt = ST_IDLE;
          else if (last_beat)
            state_nxt = ST_FLUSH;
        end else if (tmo) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if ((in_valid && in_last) || tmo)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // per-state strobes; a flushed frame was already flagged
  always_comb begin
    first = 1'b0;
    good  = 1'b0;
    bad   = 1'b0;
    busy  = state != ST_IDLE;
    unique case (state)
      ST_IDLE: begin
        first = in_valid;
        bad   = in_valid && in_last;
      end
      ST_COLLECT: begin
        good = in_valid && in_last &&
          last_beat;
        bad  = in_valid ?
          (in_last != last_beat) : tmo;
      end
      default: ;
    endcase
  end

  // beat counter, idle timer and shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      tmr    <= '0;
      shadow <= '0;
    end else begin
      if (first)
        cnt <= CLS_IDX_W'(1);
      else if (state == ST_COLLECT && in_valid)
        cnt <= cnt + 1'b1;
      if (busy && !in_valid && !tmo)
        tmr <= tmr + 1'b1;
      else
        tmr <= '0;
      if (in_valid)
        shadow <= {shadow[SH_W-DW-1:0], in_data};
    end
  end

  // result word only moves on a good frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= good;
      err        <= bad;
      if (good)
        dout <= {shadow, in_data};
    end
  end

`ifdef FC_COLLECT_ARGMAX_EN
  logic [CLS_IDX_W-1:0] best_idx;
  logic [DW-1:0]        best_score;

  argmax_tracker u_argmax (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (first),
    .en         (first || (state == ST_COLLECT && in_valid)),
    .data       (in_data),
    .idx        (first ? '0 : cnt),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

  // argmax result follows dout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      class_idx   <= '0;
      class_score <= '0;
    end else if (good) begin
      class_idx   <= best_idx;
      class_score <= best_score;
    end
  end
`else
  assign class_idx   = '0;
  assign class_score = '0;
`endif

endmodule

// File: tb/tb_fc_result_collector.sv
// Scoreboard bench for fc_result_collector.
// Expected argmax follows FC_COLLECT_ARGMAX_EN.
module tb_fc_result_collector;

`ifdef FC_COLLECT_ARGMAX_EN
  localparam bit ARG = 1'b1;
`else
  localparam bit ARG = 1'b0;
`endif
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic [79:0] dout;
  logic        dout_valid;
  logic        err;
  logic        busy;
  logic [3:0]  class_idx;
  logic [7:0]  class_score;

  fc_result_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .err         (err),
    .busy        (busy),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [79:0] dout;
    logic [3:0]  idx;
    logic [7:0]  score;
  } exp_t;

  exp_t        sb[$];
  logic [79:0] exp_hold = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic push_ok(input logic [79:0] d,
                         input logic [3:0] i,
                         input logic [7:0] s);
    exp_t e;
    e.is_err = 1'b0;
    e.dout   = d;
    e.idx    = ARG ? i : 4'd0;
    e.score  = ARG ? s : 8'd0;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.dout   = '0;
    e.idx    = '0;
    e.score  = '0;
    sb.push_back(e);
  endtask

  task automatic beat(input logic [7:0] d,
                      input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame10(input logic [79:0] w);
    for (int i = 0; i < 10; i++)
      beat(w[79-8*i -: 8], i == 9);
  endtask

  // monitor: pop on every event, else dout must hold
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid === 1'b1 || err === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_event",
            {78'd0, dout_valid, err}, 80'd0);
      end else begin
        e = sb.pop_front();
        chk("err", {79'd0, err},
            {79'd0, e.is_err});
        chk("dout_valid", {79'd0, dout_valid},
            {79'd0, !e.is_err});
        if (!e.is_err) begin
          chk("dout", dout, e.dout);
          chk("class_idx", {76'd0, class_idx},
              {76'd0, e.idx});
          chk("class_score", {72'd0, class_score},
              {72'd0, e.score});
          exp_hold = e.dout;
        end else begin
          chk("dout_held_err", dout, exp_hold);
        end
      end
    end else begin
      chk("dout_stable", dout, exp_hold);
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 80'd0);
    chk("rst_dv", {79'd0, dout_valid}, 80'd0);
    chk("rst_err", {79'd0, err}, 80'd0);
    chk("rst_busy", {79'd0, busy}, 80'd0);
    chk("rst_idx", {76'd0, class_idx}, 80'd0);
    chk("rst_score", {72'd0, class_score}, 80'd0);
    rst_n = 1'b1;
    idle(2);

    // basic frame
    push_ok(80'h331946000000120C1B00, 4'd2, 8'h46);
    frame10(80'h331946000000120C1B00);
    chk("busy_after_good", {79'd0, busy}, 80'd0);
    idle(3);

    // short frame
    push_err();
    for (int i = 0; i < 5; i++)
      beat(8'(8'hA0 + i), i == 4);
    chk("busy_after_short", {79'd0, busy}, 80'd0);
    idle(3);

    // long frame, then two good frames back-to-back
    for (int i = 0; i < 12; i++) begin
      if (i == 9) push_err();
      beat(8'(8'hC0 + i), i == 11);
    end
    chk("busy_after_long", {79'd0, busy}, 80'd0);
    push_ok(80'h057F80000000007F0000, 4'd1, 8'h7F);
    frame10(80'h057F80000000007F0000);
    push_ok(80'h80818283848586878889, 4'd9, 8'h89);
    frame10(80'h80818283848586878889);
    idle(3);

    // gap of TIMEOUT-1 keeps the frame alive
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    idle(TMO - 1);
    chk("busy_in_gap", {79'd0, busy}, 80'd1);
    push_ok(80'h0102030405060708090A, 4'd9, 8'h0A);
    for (int i = 4; i <= 10; i++)
      beat(8'(i), i == 10);
    idle(3);

    // gap of TIMEOUT aborts; late beat opens a new frame
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    push_err();
    idle(TMO);
    chk("busy_after_tmo", {79'd0, busy}, 80'd0);
    push_ok(80'h40414243444546474849, 4'd9, 8'h49);
    frame10(80'h40414243444546474849);
    idle(3);

    // reset mid-frame
    for (int i = 0; i < 6; i++)
      beat(8'(8'h60 + i), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_hold = '0;
    @(posedge clk);
    #1;
    chk("midrst_dout", dout, 80'd0);
    chk("midrst_busy", {79'd0, busy}, 80'd0);
    rst_n = 1'b1;
    idle(2);
    push_ok(80'h10203040506070010203, 4'd6, 8'h70);
    frame10(80'h10203040506070010203);
    idle(5);

    chk("sb_empty", 80'(sb.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
